input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Conditions the raw control/data pins ahead of the LFSR, the seven-segment stage and the CPU mode decode.
//   Two-flop synchronises every input bit, debounces the two control buttons,
//   and decodes the operating mode: LFSR run, state load, taps load, CPU.
//   Produces clean hold levels plus one-cycle load strobes, with a data snapshot taken at the strobe.
// PARAMETERS
//   CLOCK_HZ     6250  system clock frequency, Hz
//   DEBOUNCE_MS  10    required stable time for a button change, ms
//   DATA_BITS    5     width of the data field (LFSR width)
//   derived: D = max(1, CLOCK_HZ*DEBOUNCE_MS/1000) cycles (62 at defaults); counter width $clog2(D+1)
// PORTS
//   clk                input   1          system clock, rising edge
//   rst_n_i            input   1          reset, asynchronous assert, active-low
//   reset_lfsr_raw_i   input   1          raw button: load LFSR state
//   reset_taps_raw_i   input   1          raw button: load LFSR taps
//   data_raw_i         input   DATA_BITS  raw data pins
//   reset_lfsr_o       output  1          debounced state-load level, 0 in CPU mode
//   reset_taps_o       output  1          debounced taps-load level, 0 in CPU mode
//   load_state_o       output  1          1-cycle strobe on qualified state-load press
//   load_taps_o        output  1          1-cycle strobe on qualified taps-load press
//   data_o             output  DATA_BITS  synchronised data, captured on the strobe
//   mode_cpu_o         output  1          both buttons debounced-high
// BEHAVIOUR
//   Reset: all sync flops, counters and outputs are 0; FSM is in RUN. Reset mid-count discards the count.
//   Sync: each input goes through 2 flops (s1, s2). Data bits are synchronised only, not debounced.
//   Debounce, per button, on level L:
//   - s2==L -> cnt<=0.
//   - s2!=L and cnt<D-1 -> cnt++.
//   - s2!=L and cnt==D-1 -> L<=s2, cnt<=0.
//   - Any glitch back to L before the terminal count restarts the count from 0.
//   Latency: number the first edge that samples the new raw value as edge 1; L changes at edge D+2.
//   Mode FSM (registered) on debounced levels {Lr,Lt}:
//   - RUN: {1,0} -> LOAD_S; {0,1} -> LOAD_T; {1,1} -> CPU.
//   - LOAD_S: Lr=0 -> RUN; Lt=1 -> CPU.
//   - LOAD_T: Lt=0 -> RUN; Lr=1 -> CPU.
//   - CPU: stays while either button is high; {0,0} -> RUN.
//   - From CPU, release goes through RUN only, so no strobe fires on release.
//   Strobes: load_state_o is high for exactly the one cycle after the RUN->LOAD_S transition edge; load_taps_o likewise for RUN->LOAD_T.
//   - Never both in the same cycle; never asserted in CPU.
//   - Both buttons rising on the same edge -> CPU directly, no strobe.
//   Levels: reset_lfsr_o = (state==LOAD_S); reset_taps_o = (state==LOAD_T); mode_cpu_o = (state==CPU).
//   data_o is loaded from s2 data on the edge that raises a strobe and holds otherwise, so a pin change while a button is held does not alter data_o.
//   Holding a button: a single strobe; the level output stays high until release debounces.
// STRUCTURE
//   Sub-module debounce_bit (2-flop sync + counter + level); 2 instances with parameter D.
//   Data sync, mode FSM, strobes and snapshot stay in input_conditioner.
//   FSM state encoding (RUN=0, LOAD_S=1, LOAD_T=2, CPU=3) and the D computation go in the shared project constants header, where the top-level and CPU decode also use them.
//   No other shared typedefs.
// TESTING  (bench: CLOCK_HZ=1000, DEBOUNCE_MS=4 -> D=4, DATA_BITS=5)
//   1. Reset: rst_n_i=0 with all raw inputs=1 -> all outputs 0 immediately; release -> still 0 until edge D+2=6.
//   2. data_raw=5'b10110, reset_lfsr_raw 0->1 held.
//      - reset_lfsr_o rises at edge 6; load_state_o is high for 1 cycle.
//      - data_o=10110 and stays so when the data pins change to 00001 while the button is held.
//   3. Bounce: reset_taps_raw high for 3 cycles, low 1, then high.
//      - No change until 4 consecutive stable samples.
//      - Exactly one load_taps_o pulse; data_o captured at that pulse.
//   4. Both buttons raised on the same cycle -> mode_cpu_o=1 at edge 6, zero strobes.
//      - Release one: CPU holds. Release both: RUN after debounce, no strobe.
//   5. reset_lfsr held (LOAD_S), then taps pressed -> mode_cpu_o=1, reset_lfsr_o=0, no load_taps_o.
//   6. Async reset asserted mid-debounce (cnt=2) and mid-LOAD_T -> outputs 0 at once; after release, a full D count is required.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
//   Shared project constants for the input conditioner, the top-level glue and
//   the CPU mode decode.
//   - mode_e          : operating-mode FSM state encoding
//   - debounce_cycles : debounce window length in clock cycles, minimum 1
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_LOAD_S = 2'd1,
        MODE_LOAD_T = 2'd2,
        MODE_CPU    = 2'd3
    } mode_e;

    // Product is formed in 64 bits so fast clocks with long windows do not wrap.
    function automatic int unsigned debounce_cycles(input int unsigned clock_hz,
                                                    input int unsigned debounce_ms);
        longint unsigned d;
        d = (longint'(clock_hz) * longint'(debounce_ms)) / 64'd1000;
        return (d < 64'd1) ? 1 : int'(d);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   Two-flop synchroniser followed by a stability counter for one button.
//   The level follows the synchronised input only after it has disagreed with
//   the current level on D consecutive clock edges; any agreement restarts
//   the count.
// Ports
//   clk           in   system clock, rising edge
//   rst_n_i       in   asynchronous active-low reset
//   raw_i         in   raw button pin
//   level_next_o  out  debounced level as it will be after the current edge
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int unsigned D = 4
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_next_o
);

    localparam int unsigned CW = $clog2(D + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    logic w_differs;
    logic w_terminal;

    assign w_differs  = (r_s2 != r_level);
    assign w_terminal = (r_cnt == CW'(D - 1));

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= raw_i;
            r_s2 <= r_s1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_terminal) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Exposes the value r_level takes at this edge so a downstream registered
    // decoder can change state on the same edge as the level itself.
    assign level_next_o = (w_differs && w_terminal) ? r_s2 : r_level;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Synchronises the raw control/data pins, debounces the two buttons and
//   decodes the operating mode (LFSR run, state load, taps load, CPU).
//   Produces hold levels, one-cycle load strobes and a data snapshot taken on
//   the strobe edge.
// Ports
//   clk               in   system clock, rising edge
//   rst_n_i           in   asynchronous active-low reset
//   reset_lfsr_raw_i  in   raw button: load LFSR state
//   reset_taps_raw_i  in   raw button: load LFSR taps
//   data_raw_i        in   raw data pins [DATA_BITS]
//   reset_lfsr_o      out  state-load level (LOAD_S)
//   reset_taps_o      out  taps-load level (LOAD_T)
//   load_state_o      out  1-cycle strobe on RUN->LOAD_S
//   load_taps_o       out  1-cycle strobe on RUN->LOAD_T
//   data_o            out  synchronised data captured with a strobe [DATA_BITS]
//   mode_cpu_o        out  CPU mode
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CLOCK_HZ    = 6250,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned DATA_BITS   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 reset_lfsr_raw_i,
    input  logic                 reset_taps_raw_i,
    input  logic [DATA_BITS-1:0] data_raw_i,
    output logic                 reset_lfsr_o,
    output logic                 reset_taps_o,
    output logic                 load_state_o,
    output logic                 load_taps_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 mode_cpu_o
);

    localparam int unsigned D = debounce_cycles(CLOCK_HZ, DEBOUNCE_MS);

    logic                 w_lr;
    logic                 w_lt;
    logic [DATA_BITS-1:0] r_data_s1;
    logic [DATA_BITS-1:0] r_data_s2;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_load_state;
    logic                 r_load_taps;
    mode_e                r_state;
    mode_e                w_state_next;
    logic                 w_fire_state;
    logic                 w_fire_taps;

    debounce_bit #(.D(D)) u_deb_lfsr (
        .clk          (clk),
        .rst_n_i      (rst_n_i),
        .raw_i        (reset_lfsr_raw_i),
        .level_next_o (w_lr)
    );

    debounce_bit #(.D(D)) u_deb_taps (
        .clk          (clk),
        .rst_n_i      (rst_n_i),
        .raw_i        (reset_taps_raw_i),
        .level_next_o (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= MODE_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Release from CPU always lands in RUN, so a late release of one button
    // can never be mistaken for a fresh single-button press.
    always_comb begin
        w_state_next = r_state;
        w_fire_state = 1'b0;
        w_fire_taps  = 1'b0;
        unique case (r_state)
            MODE_RUN: begin
                if (w_lr && w_lt)  w_state_next = MODE_CPU;
                else if (w_lr)     w_state_next = MODE_LOAD_S;
                else if (w_lt)     w_state_next = MODE_LOAD_T;
            end
            MODE_LOAD_S: begin
                if (!w_lr)         w_state_next = MODE_RUN;
                else if (w_lt)     w_state_next = MODE_CPU;
            end
            MODE_LOAD_T: begin
                if (!w_lt)         w_state_next = MODE_RUN;
                else if (w_lr)     w_state_next = MODE_CPU;
            end
            MODE_CPU: begin
                if (!w_lr && !w_lt) w_state_next = MODE_RUN;
            end
            default: w_state_next = MODE_RUN;
        endcase
        w_fire_state = (r_state == MODE_RUN) && (w_state_next == MODE_LOAD_S);
        w_fire_taps  = (r_state == MODE_RUN) && (w_state_next == MODE_LOAD_T);
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_data       <= '0;
            r_load_state <= 1'b0;
            r_load_taps  <= 1'b0;
        end else begin
            r_data_s1    <= data_raw_i;
            r_data_s2    <= r_data_s1;
            r_load_state <= w_fire_state;
            r_load_taps  <= w_fire_taps;
            if (w_fire_state || w_fire_taps) begin
                r_data <= r_data_s2;
            end
        end
    end

    assign reset_lfsr_o = (r_state == MODE_LOAD_S);
    assign reset_taps_o = (r_state == MODE_LOAD_T);
    assign mode_cpu_o   = (r_state == MODE_CPU);
    assign load_state_o = r_load_state;
    assign load_taps_o  = r_load_taps;
    assign data_o       = r_data;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Directed scenarios plus randomised button/data activity. A reference model
//   pushes the expected outputs for every clock edge into a queue; a monitor
//   on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int DB     = 5;
    localparam int M_RUN  = 0;
    localparam int M_LS   = 1;
    localparam int M_LT   = 2;
    localparam int M_CPU  = 3;
    localparam int DEB    = 4;   // 1000 Hz * 4 ms

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          reset_lfsr_raw_i = 1'b0;
    logic          reset_taps_raw_i = 1'b0;
    logic [DB-1:0] data_raw_i = '0;
    logic          reset_lfsr_o;
    logic          reset_taps_o;
    logic          load_state_o;
    logic          load_taps_o;
    logic [DB-1:0] data_o;
    logic          mode_cpu_o;

    always #5 clk = ~clk;

    input_conditioner #(
        .CLOCK_HZ    (1000),
        .DEBOUNCE_MS (4),
        .DATA_BITS   (DB)
    ) dut (
        .clk              (clk),
        .rst_n_i          (rst_n_i),
        .reset_lfsr_raw_i (reset_lfsr_raw_i),
        .reset_taps_raw_i (reset_taps_raw_i),
        .data_raw_i       (data_raw_i),
        .reset_lfsr_o     (reset_lfsr_o),
        .reset_taps_o     (reset_taps_o),
        .load_state_o     (load_state_o),
        .load_taps_o      (load_taps_o),
        .data_o           (data_o),
        .mode_cpu_o       (mode_cpu_o)
    );

    typedef struct packed {
        logic          rl;
        logic          rt;
        logic          ls;
        logic          lt;
        logic          cpu;
        logic [DB-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ls  = 0;
    int   n_lt  = 0;

    // ---------------- reference model ----------------
    // Pins reach the debouncer two edges after they are sampled; a button level
    // flips once the delayed pin has disagreed with it on DEB consecutive edges.
    logic          mq_r[$];
    logic          mq_t[$];
    logic [DB-1:0] mq_d[$];
    logic          m_lr, m_lt;
    int            m_run_r, m_run_t, m_mode;
    logic [DB-1:0] m_snap;

    task automatic model_reset();
        mq_r = '{1'b0, 1'b0};
        mq_t = '{1'b0, 1'b0};
        mq_d = '{'0, '0};
        m_lr = 1'b0; m_lt = 1'b0;
        m_run_r = 0; m_run_t = 0;
        m_mode = M_RUN;
        m_snap = '0;
    endtask

    function automatic void deb(input logic seen, inout logic lvl, inout int run);
        if (seen != lvl) begin
            run++;
            if (run == DEB) begin
                lvl = seen;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    initial begin : ref_model
        logic          sr, st;
        logic [DB-1:0] sd;
        int            prev;
        exp_t          e;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n_i) begin
                model_reset();
            end else begin
                sr = mq_r.pop_front(); mq_r.push_back(reset_lfsr_raw_i);
                st = mq_t.pop_front(); mq_t.push_back(reset_taps_raw_i);
                sd = mq_d.pop_front(); mq_d.push_back(data_raw_i);
                deb(sr, m_lr, m_run_r);
                deb(st, m_lt, m_run_t);
                prev = m_mode;
                if (m_lr && m_lt)         m_mode = M_CPU;
                else if (m_mode == M_CPU) m_mode = (m_lr || m_lt) ? M_CPU : M_RUN;
                else if (m_mode == M_LS)  m_mode = m_lr ? M_LS : M_RUN;
                else if (m_mode == M_LT)  m_mode = m_lt ? M_LT : M_RUN;
                else                      m_mode = m_lr ? M_LS : (m_lt ? M_LT : M_RUN);
                e.ls  = (prev == M_RUN) && (m_mode == M_LS);
                e.lt  = (prev == M_RUN) && (m_mode == M_LT);
                if (e.ls || e.lt) m_snap = sd;
                e.rl   = (m_mode == M_LS);
                e.rt   = (m_mode == M_LT);
                e.cpu  = (m_mode == M_CPU);
                e.data = m_snap;
                sb.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t act, want;
        forever begin
            @(negedge clk);
            act = '{reset_lfsr_o, reset_taps_o, load_state_o, load_taps_o, mode_cpu_o, data_o};
            if (!rst_n_i) begin
                sb.delete();
                n_cmp++;
                if (act !== '0) begin
                    n_err++;
                    $display("FAIL reset_hold t=%0t got=%h want=0", $time, act);
                end
            end else begin
                n_ls += int'(load_state_o);
                n_lt += int'(load_taps_o);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty t=%0t got=%h want=<queued entry>", $time, act);
                end else begin
                    want = sb.pop_front();
                    if (act !== want) begin
                        n_err++;
                        $display("FAIL scoreboard t=%0t got rl/rt/ls/lt/cpu/data=%b/%b/%b/%b/%b/%b want=%b/%b/%b/%b/%b/%b",
                                 $time, act.rl, act.rt, act.ls, act.lt, act.cpu, act.data,
                                 want.rl, want.rt, want.ls, want.lt, want.cpu, want.data);
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // Leaves time at 1 unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {reset_lfsr_o, reset_taps_o, load_state_o, load_taps_o, mode_cpu_o, data_o}, 32'd0);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, hold over two edges,
    // release just after a falling edge so the next rising edge is edge 1.
    task automatic pulse_reset(input string name);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero(name);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n_i = 1'b1;
    endtask

    initial begin : watchdog
        #(60000 * 10);
        n_err++;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int b_ls, b_lt, cr, ct;

        // 1. reset with every raw input high
        reset_lfsr_raw_i = 1'b1;
        reset_taps_raw_i = 1'b1;
        data_raw_i       = '1;
        #1;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("t1_async_zero");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("t1_held_zero");
        @(negedge clk);
        #1;
        rst_n_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t1_cpu_e%0d", k), mode_cpu_o, (k >= 6));
            check($sformatf("t1_other_e%0d", k),
                  {reset_lfsr_o, reset_taps_o, load_state_o, load_taps_o, data_o}, 32'd0);
        end
        reset_lfsr_raw_i = 1'b0;
        reset_taps_raw_i = 1'b0;
        data_raw_i       = '0;
        idle(10);

        // 2. state-load press with data snapshot
        b_ls = n_ls;
        data_raw_i       = 5'b10110;
        reset_lfsr_raw_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t2_lvl_e%0d", k), reset_lfsr_o, (k >= 6));
            check($sformatf("t2_stb_e%0d", k), load_state_o, (k == 6));
            if (k == 6) check("t2_data_at_strobe", data_o, 32'h16);
            if (k == 7) data_raw_i = 5'b00001;
        end
        idle(6);
        check("t2_data_hold", data_o, 32'h16);
        check("t2_lvl_hold", reset_lfsr_o, 1'b1);
        reset_lfsr_raw_i = 1'b0;
        idle(8);
        check("t2_lvl_release", reset_lfsr_o, 1'b0);
        check("t2_one_strobe", n_ls - b_ls, 32'd1);

        // 3. bouncing taps press: high 3, low 1, then high
        b_lt = n_lt;
        data_raw_i       = 5'b01101;
        reset_taps_raw_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t3_lvl_e%0d", k), reset_taps_o, (k >= 10));
            check($sformatf("t3_stb_e%0d", k), load_taps_o, (k == 10));
            if (k == 10) check("t3_data_at_strobe", data_o, 32'h0d);
            reset_taps_raw_i = (k == 3) ? 1'b0 : 1'b1;
            if (k == 11) data_raw_i = 5'b11111;
        end
        reset_taps_raw_i = 1'b0;
        idle(8);
        check("t3_one_strobe", n_lt - b_lt, 32'd1);
        check("t3_data_kept", data_o, 32'h0d);

        // 4. both buttons together -> CPU, no strobes on entry or release
        b_ls = n_ls; b_lt = n_lt;
        reset_lfsr_raw_i = 1'b1;
        reset_taps_raw_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t4_cpu_e%0d", k), mode_cpu_o, (k >= 6));
        end
        reset_taps_raw_i = 1'b0;
        idle(10);
        check("t4_cpu_one_held", mode_cpu_o, 1'b1);
        reset_lfsr_raw_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t4_rel_e%0d", k), mode_cpu_o, (k < 6));
        end
        idle(4);
        check("t4_no_strobes", (n_ls - b_ls) + (n_lt - b_lt), 32'd0);

        // 5. LOAD_S held, taps added -> CPU without a taps strobe
        reset_lfsr_raw_i = 1'b1;
        idle(8);
        check("t5_in_load_s", reset_lfsr_o, 1'b1);
        b_ls = n_ls; b_lt = n_lt;
        reset_taps_raw_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t5_cpu_e%0d", k), mode_cpu_o, (k >= 6));
            check($sformatf("t5_rl_e%0d", k), reset_lfsr_o, (k < 6));
        end
        check("t5_no_strobes", (n_ls - b_ls) + (n_lt - b_lt), 32'd0);
        reset_lfsr_raw_i = 1'b0;
        reset_taps_raw_i = 1'b0;
        idle(10);

        // 6a. reset while in LOAD_T, button still held -> full recount
        reset_taps_raw_i = 1'b1;
        data_raw_i       = 5'b10011;
        idle(8);
        check("t6_in_load_t", reset_taps_o, 1'b1);
        pulse_reset("t6a_async_zero");
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t6a_lvl_e%0d", k), reset_taps_o, (k >= 6));
            check($sformatf("t6a_stb_e%0d", k), load_taps_o, (k == 6));
        end
        reset_taps_raw_i = 1'b0;
        idle(8);

        // 6b. reset with the counter part-way (cnt=2 after edge 4)
        reset_lfsr_raw_i = 1'b1;
        idle(4);
        pulse_reset("t6b_async_zero");
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t6b_lvl_e%0d", k), reset_lfsr_o, (k >= 6));
        end
        reset_lfsr_raw_i = 1'b0;
        idle(8);

        // 7. random button/data activity, checked by the scoreboard only
        cr = 0; ct = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (cr == 0) begin
                reset_lfsr_raw_i = 1'($urandom_range(0, 1));
                cr = int'($urandom_range(1, 10));
            end else begin
                cr--;
            end
            if (ct == 0) begin
                reset_taps_raw_i = 1'($urandom_range(0, 1));
                ct = int'($urandom_range(1, 10));
            end else begin
                ct--;
            end
            if ($urandom_range(0, 3) == 0) data_raw_i = DB'($urandom);
            if (i % 1000 == 777) pulse_reset("t7_async_zero");
        end
        reset_lfsr_raw_i = 1'b0;
        reset_taps_raw_i = 1'b0;
        idle(12);
        check("final_idle_mode", {reset_lfsr_o, reset_taps_o, mode_cpu_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
